l2_rsp_model: RTL and testbench

- Synthesizable L2-side responder for the L1 controller's per-stream cacheline request/response interface.
- Accepts one-bit cacheline requests from up to nstrms streams through a round-robin arbiter.
- Delays each accepted request by a fixed, configurable latency, then queues it.
- Returns one response pulse to the originating stream with full valid/ready backpressure.
- Replaces the single-register loopback in L1 benches and system bring-up; gives realistic latency, ordering and credit limits.

---
 rtl/l2_rsp_model.sv | 155 +++++++++++++++
 tb/tb_l2_rsp_model.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_rsp_model.sv
// l2_rsp_model: L2-side responder for the L1 per-stream cacheline interface.
// Requests from up to nstrms streams are arbitrated round-robin, delayed by a
// fixed lat-stage pipeline, queued in acceptance order, and answered with one
// response pulse per request on the originating stream's lane.
//
// Ports:
//   clk      clock
//   reset    synchronous active-high reset
//   i_req_v  per-stream request valid
//   i_req_r  per-stream request ready (one-hot or zero)
//   o_rsp_v  per-stream response valid (one-hot or zero)
//   o_rsp_r  per-stream response ready
//   o_outst  requests currently outstanding (pipeline plus queue)
//   o_full   o_outst == qdepth
module l2_rsp_model #(
   parameter int nstrms    = 64,
   parameter int sid_width = $clog2(nstrms),
   parameter int lat       = 4,
   parameter int qdepth    = 16,
   parameter int cnt_width = $clog2(qdepth + 1)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [nstrms-1:0]    i_req_v,
   output logic [nstrms-1:0]    i_req_r,
   output logic [nstrms-1:0]    o_rsp_v,
   input  logic [nstrms-1:0]    o_rsp_r,
   output logic [cnt_width-1:0] o_outst,
   output logic                 o_full
);

   localparam int aw = $clog2(qdepth);
   localparam logic [sid_width:0] nstrms_w = (sid_width + 1)'(nstrms);

   logic [sid_width-1:0] rr_ptr;
   logic [sid_width-1:0] grant_sid;
   logic [sid_width-1:0] idx;
   logic [sid_width:0]   sum;
   logic                 found;
   logic                 credit_ok;
   logic                 accept;

   // Search starts at the RR pointer and wraps modulo nstrms.
   always_comb begin
      found     = 1'b0;
      grant_sid = '0;
      sum       = '0;
      idx       = '0;
      for (int i = 0; i < nstrms; i++) begin
         sum = {1'b0, rr_ptr} + (sid_width + 1)'(i);
         if (sum >= nstrms_w) sum = sum - nstrms_w;
         idx = sum[sid_width-1:0];
         if (!found && i_req_v[idx]) begin
            found     = 1'b1;
            grant_sid = idx;
         end
      end
   end

   // Credit is taken from the registered count only, so a pop at full does
   // not open the door in the same cycle.
   assign credit_ok = (o_outst < cnt_width'(qdepth));
   assign accept    = found && credit_ok && !reset;

   always_comb begin
      i_req_r = '0;
      if (accept) i_req_r[grant_sid] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (accept) begin
         if (grant_sid == sid_width'(nstrms - 1)) rr_ptr <= '0;
         else                                      rr_ptr <= grant_sid + sid_width'(1);
      end
   end

   logic                 wr_en;
   logic [sid_width-1:0] wr_sid;

   generate
      if (lat == 0) begin : g_nopipe
         assign wr_en  = accept;
         assign wr_sid = grant_sid;
      end else begin : g_pipe
         logic [lat-1:0]       pipe_v;
         logic [sid_width-1:0] pipe_sid [lat];

         always_ff @(posedge clk) begin
            if (reset) begin
               pipe_v <= '0;
            end else begin
               pipe_v[0] <= accept;
               for (int k = 1; k < lat; k++) pipe_v[k] <= pipe_v[k-1];
            end
            pipe_sid[0] <= grant_sid;
            for (int k = 1; k < lat; k++) pipe_sid[k] <= pipe_sid[k-1];
         end

         assign wr_en  = pipe_v[lat-1];
         assign wr_sid = pipe_sid[lat-1];
      end
   endgenerate

   // Queue never overflows: the credit check bounds pipeline plus queue.
   logic [sid_width-1:0] mem [qdepth];
   logic [aw:0]          wr_ptr;
   logic [aw:0]          rd_ptr;
   logic [sid_width-1:0] head_sid;
   logic                 q_empty;
   logic                 pop;

   assign q_empty  = (wr_ptr == rd_ptr);
   assign head_sid = mem[rd_ptr[aw-1:0]];
   assign pop      = !q_empty && !reset && o_rsp_r[head_sid];

   always_comb begin
      o_rsp_v = '0;
      if (!q_empty && !reset) o_rsp_v[head_sid] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[aw-1:0]] <= wr_sid;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (aw + 1)'(1);
         if (pop)   rd_ptr <= rd_ptr + (aw + 1)'(1);
      end
   end

   logic [cnt_width-1:0] outst_nxt;

   always_comb begin
      outst_nxt = o_outst;
      if (accept && !pop)      outst_nxt = o_outst + cnt_width'(1);
      else if (!accept && pop) outst_nxt = o_outst - cnt_width'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_outst <= '0;
         o_full  <= 1'b0;
      end else begin
         o_outst <= outst_nxt;
         o_full  <= (outst_nxt == cnt_width'(qdepth));
      end
   end

endmodule

// File: tb/tb_l2_rsp_model.sv
// Bench for l2_rsp_model: two instances (lat=4 and lat=0) share stimulus.
// A queue-of-(sid, visible-cycle) model predicts every output each cycle;
// directed sections pin the model with hand-computed literals.
module tb_l2_rsp_model;

   localparam int NS   = 64;
   localparam int QD   = 16;
   localparam int LAT0 = 4;
   localparam int LAT1 = 0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] req_v = '0;
   logic [63:0] rsp_r = '1;
   logic [63:0] rdy0, rdy1, rsp0, rsp1;
   logic [4:0]  outst0, outst1;
   logic        full0, full1;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   l2_rsp_model #(.nstrms(NS), .lat(LAT0), .qdepth(QD)) dut0 (
      .clk(clk), .reset(reset), .i_req_v(req_v), .i_req_r(rdy0),
      .o_rsp_v(rsp0), .o_rsp_r(rsp_r), .o_outst(outst0), .o_full(full0));

   l2_rsp_model #(.nstrms(NS), .lat(LAT1), .qdepth(QD)) dut1 (
      .clk(clk), .reset(reset), .i_req_v(req_v), .i_req_r(rdy1),
      .o_rsp_v(rsp1), .o_rsp_r(rsp_r), .o_outst(outst1), .o_full(full1));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // Each entry packs visible_cycle*64 + sid; count includes the pipeline.
   int mq [2][QD];
   int mh [2];
   int mc [2];
   int mp [2];
   bit mvalid = 1'b0;

   logic [63:0] a_rdy [2];
   logic [63:0] a_rsp [2];
   logic [4:0]  a_outst [2];
   logic        a_full [2];
   assign a_rdy[0] = rdy0;     assign a_rdy[1] = rdy1;
   assign a_rsp[0] = rsp0;     assign a_rsp[1] = rsp1;
   assign a_outst[0] = outst0; assign a_outst[1] = outst1;
   assign a_full[0] = full0;   assign a_full[1] = full1;

   initial begin
      for (int n = 0; n < 2; n++) begin
         mh[n] = 0; mc[n] = 0; mp[n] = 0;
      end
   end

   always @(negedge clk) begin
      logic [63:0] e_rdy, e_rsp;
      int g, hs, k, ent;
      for (int n = 0; n < 2; n++) begin
         e_rdy = '0;
         e_rsp = '0;
         g = -1;
         hs = -1;
         if (!reset && mc[n] < QD) begin
            for (int i = 0; i < NS; i++) begin
               k = (mp[n] + i) % NS;
               if (g < 0 && req_v[k[5:0]]) g = k;
            end
         end
         if (g >= 0) e_rdy[g[5:0]] = 1'b1;
         if (!reset && mc[n] > 0) begin
            ent = mq[n][mh[n]];
            if (cyc >= ent / 64) begin
               hs = ent % 64;
               e_rsp[hs[5:0]] = 1'b1;
            end
         end
         check(n == 0 ? "model_rdy_lat4" : "model_rdy_lat0", a_rdy[n], e_rdy);
         check(n == 0 ? "model_rsp_lat4" : "model_rsp_lat0", a_rsp[n], e_rsp);
         if (mvalid) begin
            check(n == 0 ? "model_outst_lat4" : "model_outst_lat0", 64'(a_outst[n]), 64'(mc[n]));
            check(n == 0 ? "model_full_lat4" : "model_full_lat0", 64'(a_full[n]), 64'(mc[n] == QD));
         end
         if (reset) begin
            mc[n] = 0; mh[n] = 0; mp[n] = 0;
         end else begin
            if (hs >= 0 && rsp_r[hs[5:0]]) begin
               mh[n] = (mh[n] + 1) % QD;
               mc[n] = mc[n] - 1;
            end
            if (g >= 0) begin
               mq[n][(mh[n] + mc[n]) % QD] = (cyc + (n == 0 ? LAT0 : LAT1) + 1) * 64 + g;
               mc[n] = mc[n] + 1;
               mp[n] = (g + 1) % NS;
            end
         end
      end
      if (reset) mvalid = 1'b1;
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   int exp2 [6] = '{32, 1, 2, 32, 1, 2};
   int cnt0, cnt1;

   initial begin
      repeat (3) nxt();
      reset = 1'b0;
      repeat (3) nxt();

      // single request, latency
      req_v = 64'h2;
      @(negedge clk);
      check("t1_rdy_lat4", rdy0, 64'h2);
      check("t1_rdy_lat0", rdy1, 64'h2);
      nxt();
      req_v = '0;
      @(negedge clk);
      check("t1_outst_lat4", 64'(outst0), 64'd1);
      check("t1_outst_lat0", 64'(outst1), 64'd1);
      check("t1_rsp_lat0", rsp1, 64'h2);
      nxt();
      @(negedge clk);
      check("t1_drain_lat0", 64'(outst1), 64'd0);
      nxt();
      repeat (2) nxt();
      @(negedge clk);
      check("t1_rsp_lat4", rsp0, 64'h2);
      nxt();
      @(negedge clk);
      check("t1_drain_lat4", 64'(outst0), 64'd0);
      nxt();

      // round-robin over streams 0, 1, 5 (pointer is at 2 after stream 1)
      req_v = 64'h23;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check("t2_grant_order", rdy0, 64'(exp2[i]));
         nxt();
      end
      repeat (24) nxt();
      req_v = '0;
      repeat (12) nxt();

      // credit limit
      rsp_r = '0;
      req_v = 64'h8;
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rdy0 != 0) cnt0++;
         if (rdy1 != 0) cnt1++;
         nxt();
      end
      check("t3_accepts_lat4", 64'(cnt0), 64'd16);
      check("t3_accepts_lat0", 64'(cnt1), 64'd16);
      @(negedge clk);
      check("t3_rdy_full", rdy0, 64'h0);
      check("t3_outst_full", 64'(outst0), 64'd16);
      check("t3_full_flag", 64'(full0), 64'd1);

      // pop at full does not enable acceptance that cycle
      nxt();
      rsp_r = '1;
      @(negedge clk);
      check("t4_rdy_pop_cycle", rdy0, 64'h0);
      check("t4_rdy_pop_cycle_lat0", rdy1, 64'h0);
      check("t4_rsp_head", rsp0, 64'h8);
      nxt();
      rsp_r = '0;
      @(negedge clk);
      check("t4_rdy_next", rdy0, 64'h8);
      check("t4_outst_dip", 64'(outst0), 64'd15);
      nxt();
      @(negedge clk);
      check("t4_outst_end", 64'(outst0), 64'd16);
      check("t4_full_end", 64'(full0), 64'd1);
      nxt();

      // drain
      req_v = '0;
      rsp_r = '1;
      cnt0 = 0; cnt1 = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (rsp0 != 0) cnt0++;
         if (rsp1 != 0) cnt1++;
         nxt();
      end
      check("t3_rsp_count_lat4", 64'(cnt0), 64'd16);
      check("t3_rsp_count_lat0", 64'(cnt1), 64'd16);
      @(negedge clk);
      check("t3_outst_zero", 64'(outst0), 64'd0);
      nxt();

      // lat=0 loopback and head-of-line blocking
      req_v = 64'h80;
      rsp_r = ~64'h80;
      @(negedge clk);
      nxt();
      req_v = 64'h4;
      @(negedge clk);
      check("t5_rsp_next_cycle", rsp1, 64'h80);
      nxt();
      req_v = '0;
      @(negedge clk);
      check("t5_rsp_hold1", rsp1, 64'h80);
      nxt();
      @(negedge clk);
      check("t5_rsp_hold2", rsp1, 64'h80);
      nxt();
      rsp_r = '1;
      @(negedge clk);
      check("t5_rsp_hold3", rsp1, 64'h80);
      nxt();
      @(negedge clk);
      check("t5_rsp_behind", rsp1, 64'h4);
      nxt();
      repeat (10) nxt();

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         int mode;
         mode = (c / 250) % 4;
         case ($urandom_range(0, 3))
            0: req_v = '0;
            1: req_v = 64'h1 << $urandom_range(0, 63);
            2: req_v = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            default: req_v = {$urandom(), $urandom()};
         endcase
         case (mode)
            0: rsp_r = '1;
            1: rsp_r = {$urandom(), $urandom()};
            2: rsp_r = {$urandom(), $urandom()} & {$urandom(), $urandom()} & {$urandom(), $urandom()};
            default: rsp_r = ($urandom_range(0, 7) == 0) ? '1 : '0;
         endcase
         reset = ($urandom_range(0, 399) == 0);
         nxt();
      end

      // reset mid-operation
      reset = 1'b1;
      req_v = '0;
      rsp_r = '0;
      repeat (2) nxt();
      reset = 1'b0;
      repeat (2) nxt();
      for (int i = 0; i < 5; i++) begin
         req_v = 64'h1 << (10 + i);
         nxt();
      end
      req_v = '0;
      @(negedge clk);
      check("t6_outst_before", 64'(outst0), 64'd5);
      check("t6_outst_before_lat0", 64'(outst1), 64'd5);
      nxt();
      reset = 1'b1;
      req_v = 64'h400;
      @(negedge clk);
      check("t6_rdy_in_reset", rdy0, 64'h0);
      nxt();
      reset = 1'b0;
      req_v = '0;
      @(negedge clk);
      check("t6_outst_after", 64'(outst0), 64'd0);
      check("t6_outst_after_lat0", 64'(outst1), 64'd0);
      check("t6_rsp_after", rsp0, 64'h0);
      nxt();
      rsp_r = '1;
      cnt0 = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rsp0 != 0 || rsp1 != 0) cnt0++;
         nxt();
      end
      check("t6_no_stale_rsp", 64'(cnt0), 64'd0);
      req_v = 64'h0000_0100_0000_0001;
      @(negedge clk);
      check("t6_rr_restart", rdy0, 64'h1);
      check("t6_rr_restart_lat0", rdy1, 64'h1);
      nxt();
      req_v = '0;
      repeat (10) nxt();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
